// File: rtl/raster_pkg.sv
// raster_pkg: shared fixed-point constants, pixel word layout and writer FSM states
// FP_FRAC/FP_ONE describe signed 16.16 values; DEPTH_*/RGB_* locate fields in the 64-bit pixel word.
package raster_pkg;
    localparam int FP_FRAC = 16;
    localparam logic [31:0] FP_ONE = 32'h0001_0000;
    localparam int DEPTH_MSB = 63;
    localparam int DEPTH_LSB = 32;
    localparam int RGB_MSB = 23;
    localparam int RGB_LSB = 0;
    typedef enum logic [2:0] {S_IDLE, S_SHADE, S_READ, S_RDWAIT, S_WRITE} fdw_state_t;
    function automatic logic [63:0] pixel_word(input logic [31:0] depth, input logic [23:0] rgb);
        logic [63:0] w;
        w = '0;
        w[DEPTH_MSB:DEPTH_LSB] = depth;
        w[RGB_MSB:RGB_LSB] = rgb;
        return w;
    endfunction
endpackage

// File: rtl/fragment_depth_writer_if.sv
// fragment_depth_writer_if: Avalon-MM style pixel memory bus
// master drives mem_address/mem_read/mem_write/mem_writedata; slave returns
// mem_readdata/mem_readdatavalid and stalls with mem_waitrequest.
interface fragment_depth_writer_if #(parameter int ADDR_W = 26);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [63:0]       mem_writedata;
    logic [63:0]       mem_readdata;
    logic              mem_readdatavalid;
    logic              mem_waitrequest;
    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_readdatavalid, mem_waitrequest
    );
    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_readdatavalid, mem_waitrequest
    );
endinterface

// File: rtl/color_blend_channel.sv
// color_blend_channel: barycentric blend of one 8-bit colour channel, clamped to 0..255
// w1_i/w2_i/w3_i: signed 16.16 weights; c1_i/c2_i/c3_i: vertex channel values; c_o: blended channel.
module color_blend_channel
    import raster_pkg::*;
(
    input  logic [31:0] w1_i,
    input  logic [31:0] w2_i,
    input  logic [31:0] w3_i,
    input  logic [7:0]  c1_i,
    input  logic [7:0]  c2_i,
    input  logic [7:0]  c3_i,
    output logic [7:0]  c_o
);
    logic signed [42:0] sum;
    logic signed [42:0] shr;
    always_comb begin
        sum = 43'($signed(w1_i)) * 43'($signed({1'b0, c1_i}))
            + 43'($signed(w2_i)) * 43'($signed({1'b0, c2_i}))
            + 43'($signed(w3_i)) * 43'($signed({1'b0, c3_i}));
        shr = sum >>> FP_FRAC;
        // negative sums clamp to 0, anything with bits above 7 clamps to 255
        c_o = sum[42] ? 8'h00 : (|shr[42:8]) ? 8'hFF : shr[7:0];
    end
endmodule

// File: rtl/fragment_depth_writer.sv
// fragment_depth_writer: shades a fragment, depth-tests it against memory and writes {depth, rgb}
// clock/reset (async, active-low); in_valid + fragment fields in, stall_out back to the rasterizer;
// done_in -> done_out once drained; mem: Avalon-MM master; frags_written/frags_rejected counters.
module fragment_depth_writer
    import raster_pkg::*;
#(
    parameter int ADDR_W     = 26,
    parameter bit DEPTH_TEST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [23:0]       color1_in,
    input  logic [23:0]       color2_in,
    input  logic [23:0]       color3_in,
    input  logic [31:0]       w1_in,
    input  logic [31:0]       w2_in,
    input  logic [31:0]       depth_in,
    input  logic              done_in,
    output logic              stall_out,
    output logic              done_out,
    output logic [31:0]       frags_written,
    output logic [31:0]       frags_rejected,
    fragment_depth_writer_if.master mem
);
    fdw_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0] c1_q, c2_q, c3_q, rgb_q, rgb_d;
    logic [31:0] w1_q, w2_q, w3, depth_q;
    logic [31:0] written_q, written_d, rejected_q, rejected_d;
    logic done_q;
    assign w3 = FP_ONE - w1_q - w2_q;
    for (genvar i = 0; i < 3; i++) begin : g_ch
        color_blend_channel u_ch (
            .w1_i(w1_q), .w2_i(w2_q), .w3_i(w3),
            .c1_i(c1_q[8*i +: 8]), .c2_i(c2_q[8*i +: 8]), .c3_i(c3_q[8*i +: 8]),
            .c_o (rgb_d[8*i +: 8])
        );
    end
    always_comb begin
        state_d    = state_q;
        written_d  = written_q;
        rejected_d = rejected_q;
        case (state_q)
            S_IDLE:   state_d = in_valid ? S_SHADE : S_IDLE;
            S_SHADE:  state_d = DEPTH_TEST ? S_READ : S_WRITE;
            S_READ:   state_d = mem.mem_waitrequest ? S_READ : S_RDWAIT;
            S_RDWAIT: if (mem.mem_readdatavalid) begin
                // strictly closer wins; equal depth is rejected
                if ($signed(depth_q) < $signed(mem.mem_readdata[DEPTH_MSB:DEPTH_LSB])) begin
                    state_d = S_WRITE;
                end else begin
                    state_d    = S_IDLE;
                    rejected_d = rejected_q + 32'd1;
                end
            end
            S_WRITE:  if (!mem.mem_waitrequest) begin
                state_d   = S_IDLE;
                written_d = written_q + 32'd1;
            end
            default:  state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            c1_q       <= '0;
            c2_q       <= '0;
            c3_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            depth_q    <= '0;
            rgb_q      <= '0;
            written_q  <= '0;
            rejected_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            written_q  <= written_d;
            rejected_q <= rejected_d;
            done_q     <= done_in && state_q == S_IDLE && !in_valid;
            if (state_q == S_IDLE && in_valid) begin
                addr_q  <= addr_in;
                c1_q    <= color1_in;
                c2_q    <= color2_in;
                c3_q    <= color3_in;
                w1_q    <= w1_in;
                w2_q    <= w2_in;
                depth_q <= depth_in;
            end
            if (state_q == S_SHADE) rgb_q <= rgb_d;
        end
    end
    assign stall_out          = state_q != S_IDLE;
    assign done_out           = done_q;
    assign frags_written      = written_q;
    assign frags_rejected     = rejected_q;
    assign mem.mem_read       = state_q == S_READ;
    assign mem.mem_write      = state_q == S_WRITE;
    assign mem.mem_address    = (state_q == S_READ || state_q == S_WRITE) ? addr_q : '0;
    assign mem.mem_writedata  = state_q == S_WRITE ? pixel_word(depth_q, rgb_q) : '0;
endmodule

// File: doc/fragment_depth_writer.md
Name: fragment_depth_writer

Overview:
Stage directly downstream of the triangle rasterizer. It accepts one fragment at a time: frame-buffer address, three vertex colours, barycentric weights w1 and w2, and an interpolated depth. It blends the colour per channel and reads the stored depth at the pixel address. If the fragment passes the depth test, it writes a 64-bit pixel word {depth, colour} back through an Avalon-MM style memory master.

Parameters:
ADDR_W, 26, frame-buffer byte-address width
DEPTH_TEST, 1, 1 = write only if new depth < stored depth (signed 16.16); 0 = always write (no read issued)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low
in_valid  in  1  fragment valid from rasterizer (held until stall_out low)
addr_in  in  ADDR_W  pixel word byte address (8-byte aligned)
color1_in, color2_in, color3_in  in  24 each  RGB888 vertex colours
w1_in, w2_in  in  32 each  signed 16.16 barycentric weights
depth_in  in  32  signed 16.16 fragment depth
done_in  in  1  rasterizer finished triangle
stall_out  out  1  high = not accepting (to rasterizer stall_in)
done_out  out  1  done propagated once drained
mem_address  out  ADDR_W  memory byte address
mem_read  out  1  read request
mem_write  out  1  write request
mem_writedata  out  64  pixel word
mem_readdata  in  64  read data
mem_readdatavalid  in  1  read data valid
mem_waitrequest  in  1  slave stall
frags_written  out  32  count of fragments written
frags_rejected  out  32  count of fragments failing depth test

Behaviour:
- Pixel word layout: [63:32] depth (16.16), [31:24] zero, [23:0] RGB (R in [23:16]).
- Reset: state S_IDLE.
  - mem_read, mem_write, done_out = 0; both counters = 0; mem_address, mem_writedata = 0.
  - Reset mid-transaction drops requests immediately; no completion is required.
- stall_out is combinational: 1 when state != S_IDLE. During reset it is 0.
- Accept: in the cycle where state == S_IDLE and in_valid = 1, register all inputs and go to S_SHADE. in_valid while busy is ignored; the upstream block holds it.
- S_SHADE (1 cycle):
  - w3 = 0x00010000 - w1 - w2.
  - Per channel c in 0..255: sum = w1*c1 + w2*c2 + w3*c3, computed as a 43-bit signed value.
  - Result = sum >>> 16 (truncate). If < 0, clamp to 0; if > 255, clamp to 255.
  - Next state: S_READ if DEPTH_TEST, else S_WRITE.
- S_READ: mem_address = addr; mem_read = 1. Hold until mem_waitrequest = 0, then go to S_RDWAIT with mem_read = 0.
- S_RDWAIT: wait for mem_readdatavalid.
  - On valid, if signed depth < readdata[63:32], go to S_WRITE.
  - Otherwise increment frags_rejected and return to S_IDLE.
- S_WRITE: mem_write = 1, mem_writedata = {depth, 8'h0, rgb}. Hold until mem_waitrequest = 0, then increment frags_written and go to S_IDLE.
- mem_read and mem_write are never asserted together.
- Minimum latency (zero waitrequest, readdatavalid one cycle after the read is accepted):
  - accept at t, read at t+2, data at t+3, write at t+4, S_IDLE at t+5.
  - A rejected fragment reaches S_IDLE at t+4.
- Equal depth is rejected.
- done_out is registered: done_out <= done_in & (state == S_IDLE) & !in_valid. The last fragment is therefore fully committed before done_out rises.
- Counters wrap modulo 2^32.
- readdatavalid outside S_RDWAIT is ignored.

Decomposition:
- Shared package raster_pkg holds:
  - FP_FRAC = 16 and FP_ONE = 32'h0001_0000
  - pixel word field positions (DEPTH_MSB/LSB, RGB_MSB/LSB)
  - the state enum fdw_state_t {S_IDLE, S_SHADE, S_READ, S_RDWAIT, S_WRITE}
- One sub-module, color_blend_channel: combinational blend and clamp of one 8-bit channel from three weights. Instantiated three times.

Test Plan:
- Pass, pure vertex 1: w1=0x10000, w2=0, c1=0xFF0000, depth=0x00030000, stored word depth 0x00050000, addr=0x1400 → one read at 0x1400, then a write of 0x00030000_00FF0000 at 0x1400; frags_written=1; stall_out high from t+1 until return to S_IDLE.
- Reject: depth 0x00070000 vs stored 0x00050000 → no mem_write ever; frags_rejected=1; S_IDLE 4 cycles after accept. Repeat with equal depths → also rejected.
- Blend and clamp:
  - w1=w2=0x5555, c1=0x00FF00, c2=0x0000FF, c3=0xFF0000 → written RGB = 0x555454 (truncation).
  - w1=0x18000, w2=0, c1=0xC80000 → R clamps to 0xFF.
  - w1=0x18000, w2=0, c3=0x0000C8 → B clamps to 0x00.
- Backpressure: mem_waitrequest high for 3 cycles on both read and write → mem_read and mem_write each held steady with stable address/data; in_valid held throughout is not re-accepted; exactly one write occurs.
- Done and reset:
  - done_in=1 with in_valid=1 on the last fragment → done_out stays 0 until that fragment completes, then rises one cycle after S_IDLE.
  - reset asserted during S_WRITE → mem_write, counters and done_out go to 0 immediately.
- DEPTH_TEST=0: any fragment → no mem_read; write issued at t+2.
